// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts a WIDTH-bit word over load/ready and shifts it out
// one bit per clock, reloading on the final bit so consecutive words stream without a gap.
module word_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_i,
    input  logic             load_i,
    input  logic             abort_i,
    output logic             ready_o,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             last_o
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy;
    logic             at_last;
    logic             accept;
    logic [WIDTH-1:0] sreg_shifted;

    assign busy    = (state_q == StShift);
    assign at_last = busy && (cnt_q == CntLast);
    assign accept  = load_i && ready_o;

    // Shift toward the output end, zero-filling the vacated bit.
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        ready_o      = !abort_i && (!busy || at_last);
        sout_valid_o = busy;
        last_o       = at_last;
        if (busy) begin
            sout_o = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
        end else begin
            sout_o = IDLE_BIT;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        if (abort_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sreg_d  = din_i;
                        cnt_d   = '0;
                        state_d = StShift;
                    end
                end
                StShift: begin
                    if (cnt_q != CntLast) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + 1'b1;
                    end else if (accept) begin
                        sreg_d = din_i;
                        cnt_d  = '0;
                    end else begin
                        cnt_d   = '0;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: an MSB-first (idle 0) and an LSB-first (idle 1) instance share
// stimulus and are checked against a queue of bits still owed on each serial output.
module tb_word_serializer;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         load;
    logic         abort;
    logic         m_ready, m_sout, m_valid, m_last;
    logic         l_ready, l_sout, l_valid, l_last;
    logic [5:0]   obs;

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .rst(rst), .din_i(din), .load_i(load), .abort_i(abort),
        .ready_o(m_ready), .sout_o(m_sout), .sout_valid_o(m_valid), .last_o(m_last)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .din_i(din), .load_i(load), .abort_i(abort),
        .ready_o(l_ready), .sout_o(l_sout), .sout_valid_o(l_valid), .last_o(l_last)
    );

    always #5 clk = ~clk;

    assign obs = {m_sout, m_valid, m_last, l_sout, l_valid, l_last};

    int   total = 0;
    int   bad = 0;
    bit   qm[$];
    bit   ql[$];
    logic exp_ready;
    logic [1:0] obs_ready;

    // Queues hold the bits still to appear on sout, front = bit currently driven.
    function automatic logic [5:0] exp_out();
        logic mb, lb;
        mb = (qm.size() != 0) ? qm[0] : 1'b0;
        lb = (ql.size() != 0) ? ql[0] : 1'b1;
        return {mb, qm.size() != 0, qm.size() == 1, lb, ql.size() != 0, ql.size() == 1};
    endfunction

    // Drives one clock cycle; starts and ends 1 time unit after a rising edge.
    task automatic cycle(input logic ld, input logic [W-1:0] d, input logic ab);
        bit tmp;
        load  = ld;
        din   = d;
        abort = ab;
        #2;
        exp_ready = !ab && (qm.size() <= 1);
        obs_ready = {m_ready, l_ready};
        @(posedge clk);
        if (ab) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() != 0) begin
                tmp = qm.pop_front();
                tmp = ql.pop_front();
            end
            if (ld && exp_ready) begin
                for (int b = W - 1; b >= 0; b--) qm.push_back(d[b]);
                for (int b = 0; b < W; b++) ql.push_back(d[b]);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; abort = 1'b0; din = '0;
        #1;
        total++; if (obs !== 6'b000100) begin bad++;
            $display("FAIL reset_outputs: got %b want %b", obs, 6'b000100); end
        total++; if ({m_ready, l_ready} !== 2'b11) begin bad++;
            $display("FAIL reset_ready: got %b want 11", {m_ready, l_ready}); end
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        #2; rst = 1'b1; #1;
        qm.delete(); ql.delete();
        total++; if (obs !== 6'b000100) begin bad++;
            $display("FAIL reset_midword: got %b want %b", obs, 6'b000100); end
        total++; if ({m_ready, l_ready} !== 2'b11) begin bad++;
            $display("FAIL reset_midword_ready: got %b want 11", {m_ready, l_ready}); end
        @(posedge clk); #1;
        total++; if (obs !== 6'b000100) begin bad++;
            $display("FAIL reset_held: got %b want %b", obs, 6'b000100); end
        rst = 1'b0;
        cycle(1'b1, 8'hB0, 1'b0);
        total++; if ({m_sout, m_valid} !== 2'b11) begin bad++;
            $display("FAIL reset_restart_bit7: got %b want 11", {m_sout, m_valid}); end
        for (int i = 0; i < W; i++) begin
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL reset_drain[%0d]: got %b want %b", i, obs, exp_out()); end
            cycle(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_single();
        logic [7:0] s = '0;
        logic [3:0] win = '0;
        int hits = 0;
        cycle(1'b1, 8'hB0, 1'b0);
        for (int i = 0; i < W; i++) begin
            s   = {s[6:0], m_sout};
            win = {win[2:0], m_sout};
            if (win == 4'b1011) hits++;
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL single_model[%0d]: got %b want %b", i, obs, exp_out()); end
            total++; if (m_last !== (i == W - 1)) begin bad++;
                $display("FAIL single_last[%0d]: got %b want %b", i, m_last, i == W - 1); end
            cycle(1'b0, 8'h00, 1'b0);
            total++; if (obs_ready !== {2{i == W - 1}}) begin bad++;
                $display("FAIL single_ready[%0d]: got %b want %b", i, obs_ready, {2{i == W - 1}});
            end
        end
        total++; if (s !== 8'hB0) begin bad++;
            $display("FAIL single_stream: got %h want b0", s); end
        total++; if (hits != 1) begin bad++;
            $display("FAIL single_1011_count: got %0d want 1", hits); end
        total++; if (m_valid !== 1'b0) begin bad++;
            $display("FAIL single_idle_after: got %b want 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] s = '0;
        logic [15:0] v = '0;
        cycle(1'b1, 8'h05, 1'b0);
        for (int i = 0; i < 2 * W; i++) begin
            s = {s[14:0], m_sout};
            v = {v[14:0], m_valid};
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL b2b_model[%0d]: got %b want %b", i, obs, exp_out()); end
            cycle(i <= 7, 8'hB0, 1'b0);
        end
        total++; if (s !== 16'h05B0) begin bad++;
            $display("FAIL b2b_stream: got %h want 05b0", s); end
        total++; if (v !== 16'hFFFF) begin bad++;
            $display("FAIL b2b_valid: got %h want ffff", v); end
        total++; if (s[10:7] !== 4'b1011) begin bad++;
            $display("FAIL b2b_straddle: got %b want 1011", s[10:7]); end
        total++; if (m_valid !== 1'b0) begin bad++;
            $display("FAIL b2b_idle_after: got %b want 0", m_valid); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] s = '0;
        cycle(1'b1, 8'h0D, 1'b0);
        for (int i = 0; i < W; i++) begin
            s = {s[6:0], l_sout};
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL lsb_model[%0d]: got %b want %b", i, obs, exp_out()); end
            cycle(1'b0, 8'h00, 1'b0);
        end
        total++; if (s !== 8'hB0) begin bad++;
            $display("FAIL lsb_stream: got %b want 10110000", s); end
        total++; if ({l_sout, l_valid} !== 2'b10) begin bad++;
            $display("FAIL lsb_idle_bit: got %b want 10", {l_sout, l_valid}); end
    endtask

    task automatic test_abort();
        cycle(1'b1, 8'hA5, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1);
        total++; if (obs_ready !== 2'b00) begin bad++;
            $display("FAIL abort_ready: got %b want 00", obs_ready); end
        total++; if (obs !== 6'b000100) begin bad++;
            $display("FAIL abort_idle: got %b want %b", obs, 6'b000100); end
        cycle(1'b1, 8'h3C, 1'b0);
        total++; if (obs_ready !== 2'b11) begin bad++;
            $display("FAIL abort_reaccept_ready: got %b want 11", obs_ready); end
        total++; if ({m_valid, l_valid} !== 2'b11) begin bad++;
            $display("FAIL abort_reaccept: got %b want 11", {m_valid, l_valid}); end
        for (int i = 0; i < W; i++) begin
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL abort_model[%0d]: got %b want %b", i, obs, exp_out()); end
            cycle(1'b0, 8'h00, 1'b0);
        end
        cycle(1'b0, 8'h00, 1'b1);
        total++; if (obs_ready !== 2'b00 || obs !== 6'b000100) begin bad++;
            $display("FAIL abort_in_idle: got %b/%b want 00/000100", obs_ready, obs); end
    endtask

    task automatic test_ignored_load();
        logic [7:0] s = '0;
        cycle(1'b1, 8'h81, 1'b0);
        for (int i = 0; i < W; i++) begin
            s = {s[6:0], m_sout};
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL ignload_model[%0d]: got %b want %b", i, obs, exp_out()); end
            cycle(i == 3, (i == 3) ? 8'hFF : 8'h00, 1'b0);
        end
        total++; if (s !== 8'h81) begin bad++;
            $display("FAIL ignload_stream: got %h want 81", s); end
        for (int i = 0; i < 2; i++) begin
            total++; if ({m_valid, l_valid} !== 2'b00) begin bad++;
                $display("FAIL ignload_no_extra[%0d]: got %b want 00", i, {m_valid, l_valid}); end
            cycle(1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_random();
        logic         ld, ab;
        logic [W-1:0] d;
        for (int i = 0; i < 400; i++) begin
            ld = ($urandom_range(0, 3) != 0);
            ab = ($urandom_range(0, 15) == 0);
            d  = W'($urandom);
            cycle(ld, d, ab);
            total++; if (obs_ready !== {2{exp_ready}}) begin bad++;
                $display("FAIL rand_ready[%0d]: got %b want %b", i, obs_ready, {2{exp_ready}}); end
            total++; if (obs !== exp_out()) begin bad++;
                $display("FAIL rand_out[%0d]: got %b want %b", i, obs, exp_out()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_abort();
        test_ignored_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
# word_serializer

Parallel-to-serial front end for the bit-stream sequence detectors. It accepts a `WIDTH`-bit word over a valid/ready handshake and shifts it out one bit per clock on `sout`. `sout` drives the detector's serial input directly. Back-to-back words stream with no idle bubble, so patterns that straddle a word boundary remain detectable downstream.

## Interface
- `WIDTH`, 8: word width in bits; legal range 2..32.
- `MSB_FIRST`, 1: 1 = shift out `din[WIDTH-1]` first; 0 = shift out `din[0]` first.
- `IDLE_BIT`, 0: value driven on `sout` while no word is being shifted.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  `WIDTH`  parallel word; sampled only on an accepted load.
- `load`  in  1  word-valid; a word is accepted on an edge where `load && ready`.
- `abort`  in  1  synchronous; discards the word in flight and returns to idle.
- `ready`  out  1  combinational; the block can accept a word this cycle.
- `sout`  out  1  serial bit to the detector.
- `sout_valid`  out  1  high while `sout` carries a data bit.
- `last`  out  1  high while `sout` carries the final bit of the current word.

## Operation
- Registers:
  - `sreg[WIDTH-1:0]`: shift register.
  - `cnt`: bit index, `$clog2(WIDTH)` bits.
  - `busy`: FSM state.
- FSM has two states: IDLE (`busy=0`) and SHIFT (`busy=1`).
- IDLE:
  - `ready=1`.
  - On accept: `sreg<=din`, `cnt<=0`, go to SHIFT.
- SHIFT:
  - `sout` = `sreg[WIDTH-1]` if `MSB_FIRST`, else `sreg[0]`.
  - If `cnt != WIDTH-1`: shift `sreg` one place toward the output end, zero-fill, `cnt<=cnt+1`.
  - If `cnt == WIDTH-1`: this is the final bit and `ready=1`.
    - If a word is accepted: reload `sreg<=din`, `cnt<=0`, stay in SHIFT.
    - Otherwise go to IDLE.
- `ready = !abort && (!busy || cnt == WIDTH-1)`.
- `sout_valid = busy`.
- `last = busy && cnt == WIDTH-1`.
- `sout = IDLE_BIT` whenever `busy=0`.
- `abort` at an edge:
  - Sets `busy<=0` and `cnt<=0`.
  - Has priority over `load`; the word presented in that cycle is not accepted, because `ready` is already 0.
  - Is harmless in IDLE.
- `load` while `ready=0` is ignored. `din` is not sampled and the upstream must hold the word.
- `cnt` never exceeds `WIDTH-1`; there is no wrap beyond the word length.

## Timing
- Reset values, applied asynchronously while `rst=1`:
  - `busy=0`, `cnt=0`, `sreg=0`.
  - Hence `ready=1`, `sout=IDLE_BIT`, `sout_valid=0`, `last=0`.
- Reset deassertion has no latency: a load may be accepted on the first edge after `rst` falls.
- Latency: a word accepted at edge k puts its first bit on `sout` after edge k, and its bit i after edge k+i.
- `last` is high in the cycle after edge k+WIDTH-1.
- A single word keeps `sout_valid` high for exactly `WIDTH` cycles.
- Continuous `load=1` gives 100% `sout_valid` duty: one accepted word every `WIDTH` cycles.
- Reset mid-word drops the word immediately. No partial bits follow.

## Test plan
- **Reset:** assert `rst` mid-shift, WIDTH=8.
  - During reset: `sout=0`, `sout_valid=0`, `ready=1`, `last=0`.
  - After release: the next load starts cleanly at bit 7.
- **Single word:** load `8'hB0`, MSB_FIRST=1.
  - `sout` = 1,0,1,1,0,0,0,0 on the 8 cycles after accept.
  - `last` high only on the 8th cycle.
  - `ready` low on cycles 1–7.
  - A detector downstream flags 1011 once.
- **Back-to-back:** `load` held high with words `8'h05`, `8'hB0`.
  - Stream 0000010110110000 with no gap.
  - `sout_valid` high for 16 consecutive cycles.
  - The boundary-straddling 1011 is produced intact.
- **LSB-first:** MSB_FIRST=0, load `8'h0D` -> `sout` = 1,0,1,1,0,0,0,0.
- **Abort:** assert `abort` with `load` high on cycle 3 of a word.
  - The next cycle gives `sout=IDLE_BIT` and `sout_valid=0`.
  - The presented word is not accepted; it is accepted on the following edge once `abort` is low.
- **Ignored load:** pulse `load` with `din=8'hFF` mid-word while `ready=0`.
  - The output stream is unchanged and no extra word follows.
